// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with registered reads, write-to-read forwarding,
// optional hard-wired zero entry and a post-reset sweep that loads INIT_VAL everywhere.
module reg_file_2r1w #(
    parameter int                  DATA_W   = 32,
    parameter int                  ADDR_W   = 5,
    parameter logic [DATA_W-1:0]   INIT_VAL = '0,
    parameter bit                  ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              re1,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd2
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] init_ptr, init_ptr_nxt;
    logic              ready_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] rv1, rv2;

    // A user write is dropped when it targets the hard-wired zero entry.
    assign wr_ok = we && !(ZERO_REG && (wa == '0));

    always_comb begin
        state_nxt    = state;
        init_ptr_nxt = init_ptr;
        ready_nxt    = 1'b0;
        mem_we       = 1'b0;
        mem_wa       = wa;
        mem_wd       = wd;
        case (state)
            INIT: begin
                mem_we       = 1'b1;
                mem_wa       = init_ptr;
                mem_wd       = INIT_VAL;
                init_ptr_nxt = init_ptr + ADDR_W'(1);
                if (init_ptr == '1) begin
                    state_nxt = RUN;
                    ready_nxt = 1'b1;
                end
            end
            RUN: begin
                mem_we    = wr_ok;
                ready_nxt = 1'b1;
            end
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        rv1 = mem[ra1];
        if (ZERO_REG && (ra1 == '0))
            rv1 = '0;
        else if (wr_ok && (wa == ra1))
            rv1 = wd;
    end

    always_comb begin
        rv2 = mem[ra2];
        if (ZERO_REG && (ra2 == '0))
            rv2 = '0;
        else if (wr_ok && (wa == ra2))
            rv2 = wd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= INIT;
            init_ptr <= '0;
            ready    <= 1'b0;
            rd1      <= '0;
            rd2      <= '0;
        end else begin
            state    <= state_nxt;
            init_ptr <= init_ptr_nxt;
            ready    <= ready_nxt;
            if (state == RUN && re1)
                rd1 <= rv1;
            if (state == RUN && re2)
                rd2 <= rv2;
        end
    end

    // Array has no reset; the sweep is what clears it, and reset edges write nothing.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we)
            mem[mem_wa] <= mem_wd;
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: one instance with the zero register, one without,
// driven by identical stimulus and checked against hand-computed values.
module tb_reg_file_2r1w;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we, re1, re2;
    logic [4:0]  wa, ra1, ra2;
    logic [31:0] wd;

    logic        ready_z, ready_n;
    logic [31:0] rd1_z, rd2_z, rd1_n, rd2_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .INIT_VAL(32'h0), .ZERO_REG(1'b1)) dut_z (
        .clk(clk), .rst_n(rst_n), .ready(ready_z),
        .we(we), .wa(wa), .wd(wd),
        .re1(re1), .ra1(ra1), .rd1(rd1_z),
        .re2(re2), .ra2(ra2), .rd2(rd2_z)
    );

    reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .INIT_VAL(32'h0), .ZERO_REG(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .ready(ready_n),
        .we(we), .wa(wa), .wd(wd),
        .re1(re1), .ra1(ra1), .rd1(rd1_n),
        .re2(re2), .ra2(ra2), .rd2(rd2_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        chk({tag, "_ready_z"}, {31'b0, ready_z}, {31'b0, exp});
        chk({tag, "_ready_n"}, {31'b0, ready_n}, {31'b0, exp});
    endtask

    initial begin
        rst_n = 1'b0;
        we = 1'b0; wa = '0; wd = '0;
        re1 = 1'b0; ra1 = '0; re2 = 1'b0; ra2 = '0;

        // Reset held for 3 edges, then the sweep
        repeat (3) tick();
        chk_ready("rst", 1'b0);
        chk("rst_rd1", rd1_z, 32'h0);
        chk("rst_rd2", rd2_z, 32'h0);
        rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk_ready($sformatf("sweep%0d", i), (i == 32));
        end

        // All entries read zero on both ports
        re1 = 1'b1; re2 = 1'b1;
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(31 - a);
            tick();
            chk($sformatf("init_rd1_z_%0d", a), rd1_z, 32'h0);
            chk($sformatf("init_rd2_z_%0d", a), rd2_z, 32'h0);
            chk($sformatf("init_rd1_n_%0d", a), rd1_n, 32'h0);
        end
        re1 = 1'b0; re2 = 1'b0;

        // Write then read, neighbouring address unaffected
        we = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF;
        tick();
        we = 1'b0; re1 = 1'b1; ra1 = 5'd7; re2 = 1'b1; ra2 = 5'd8;
        tick();
        chk("wr_rd1", rd1_z, 32'hDEADBEEF);
        chk("wr_rd2", rd2_z, 32'h0);

        // Forwarding to both ports
        we = 1'b1; wa = 5'd9; wd = 32'h12345678; ra1 = 5'd9; ra2 = 5'd9;
        tick();
        chk("fwd_rd1", rd1_z, 32'h12345678);
        chk("fwd_rd2", rd2_z, 32'h12345678);
        chk("fwd_rd1_n", rd1_n, 32'h12345678);
        we = 1'b0; ra1 = 5'd9; ra2 = 5'd7;
        tick();
        chk("fwd_later_rd1", rd1_z, 32'h12345678);
        chk("fwd_later_rd2", rd2_z, 32'hDEADBEEF);

        // Write to entry 0 with simultaneous read
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0;
        tick();
        chk("zero_fwd_z", rd1_z, 32'h0);
        chk("zero_fwd_n", rd1_n, 32'hFFFFFFFF);
        we = 1'b0; ra1 = 5'd0; ra2 = 5'd9;
        tick();
        chk("zero_later_z", rd1_z, 32'h0);
        chk("zero_later_n", rd1_n, 32'hFFFFFFFF);
        chk("zero_later_rd2", rd2_z, 32'h12345678);

        // Hold with re1=0 while the read address is written
        ra1 = 5'd7; re2 = 1'b0;
        tick();
        chk("hold_pre", rd1_z, 32'hDEADBEEF);
        re1 = 1'b0; we = 1'b1; wa = 5'd7; wd = 32'h1;
        tick();
        chk("hold_rd1", rd1_z, 32'hDEADBEEF);
        chk("hold_rd2", rd2_z, 32'h12345678);
        we = 1'b0; re1 = 1'b1;
        tick();
        chk("hold_after", rd1_z, 32'h1);

        // Reset from RUN, then again mid-sweep at step 10
        rst_n = 1'b0;
        tick();
        chk_ready("rst_run", 1'b0);
        chk("rst_run_rd1", rd1_z, 32'h0);
        rst_n = 1'b1; re1 = 1'b1; ra1 = 5'd9; re2 = 1'b1; ra2 = 5'd9;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("sw1_rd1_%0d", i), rd1_z, 32'h0);
        end
        chk_ready("sw1", 1'b0);
        rst_n = 1'b0;
        tick();
        chk_ready("rst_mid", 1'b0);
        chk("rst_mid_rd1", rd1_z, 32'h0);
        chk("rst_mid_rd2", rd2_z, 32'h0);

        // Second sweep with writes pending on entry 3; they must be ignored
        rst_n = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'h0BAD0BAD;
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk_ready($sformatf("sweep2_%0d", i), (i == 32));
            chk($sformatf("sweep2_rd2_%0d", i), rd2_z, 32'h0);
        end
        we = 1'b0; ra1 = 5'd7; ra2 = 5'd3;
        tick();
        chk("post_rd1_z", rd1_z, 32'h0);
        chk("post_rd2_z", rd2_z, 32'h0);
        chk("post_rd2_n", rd2_n, 32'h0);
        ra1 = 5'd0; ra2 = 5'd9;
        tick();
        chk("post_zero_n", rd1_n, 32'h0);
        chk("post_rd2_9", rd2_z, 32'h0);
        chk_ready("end", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
Parametrised register file with two read ports and one write port for the datapath. It replaces the combinational, file-initialised register bank with a clocked design. Features:
- synchronous write and registered reads
- same-cycle write-to-read forwarding
- optional hard-wired zero register
- a hardware initialisation sweep after reset, so no simulation-only preload is needed

It sits between the decode stage (read addresses) and the writeback stage (write port).

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries (derived, not overridable)
INIT_VAL, 0, value written to every entry by the post-reset sweep (DATA_W bits)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  synchronous, active-low reset
ready  output  1  1 = init sweep complete, ports accept operations
we  input  1  write enable
wa  input  ADDR_W  write address
wd  input  DATA_W  write data
re1  input  1  read enable, port 1
ra1  input  ADDR_W  read address, port 1
rd1  output  DATA_W  read data, port 1 (registered)
re2  input  1  read enable, port 2
ra2  input  ADDR_W  read address, port 2
rd2  output  DATA_W  read data, port 2 (registered)

Behaviour:
- States: INIT, RUN.
- Reset (rst_n=0 at a rising edge) takes effect on that edge and applies in any state, including mid-sweep or mid-operation:
  - state <= INIT, init_ptr <= 0
  - ready <= 0, rd1 <= 0, rd2 <= 0
  - Array contents are not cleared by reset itself; the sweep clears them.
- INIT:
  - Each edge with rst_n=1 writes INIT_VAL to mem[init_ptr] and increments init_ptr.
  - On the edge that writes entry DEPTH-1: state <= RUN and ready <= 1.
  - ready therefore rises on exactly the DEPTH-th rising edge after rst_n is first sampled high.
  - we, re1 and re2 are ignored in INIT; rd1 and rd2 hold 0.
- RUN, write:
  - At an edge with we=1, mem[wa] <= wd.
  - When ZERO_REG=1 and wa=0, the write is dropped.
- RUN, read (1-cycle latency; port 1 shown, port 2 identical with re2/ra2/rd2):
  - At an edge with re1=1, rd1 <= value, where value is the first matching case:
    - 0, if ZERO_REG=1 and ra1=0
    - wd, if we=1 and wa=ra1 and the write is not dropped (forwarding)
    - mem[ra1] otherwise
  - With re1=0, rd1 holds its previous value.
- Both ports may read the same address in the same cycle; both get identical data, including the forwarded value.
- A write to one address never disturbs a read of a different address in the same cycle.
- Addresses cover the full 2**ADDR_W range, so no out-of-range case exists.
- ready stays 1 in RUN until the next reset.
- No X may propagate from the array to rd1/rd2 after ready=1.

Test Plan:
- Reset sweep: hold rst_n=0 for 3 edges, release -> ready=0 for edges 1..31, ready=1 after edge 32. Then reading all 32 addresses returns 0x00000000 on both ports.
- Write/read: write 0xDEADBEEF to addr 7. Next cycle re1=1, ra1=7 -> rd1=0xDEADBEEF one edge later. Same cycle re2=1, ra2=8 -> rd2=0.
- Forwarding: same cycle we=1, wa=9, wd=0x12345678, re1=1, ra1=9, re2=1, ra2=9 -> after that edge rd1=rd2=0x12345678. A later read of addr 9 also returns 0x12345678.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to addr 0, simultaneously read ra1=0 -> rd1=0. A later read of addr 0 -> 0.
- Zero register (ZERO_REG=0 build): same stimulus -> later read of addr 0 returns 0xFFFFFFFF.
- Hold and mid-op reset:
  - Read addr 7 (rd1=0xDEADBEEF), then set re1=0 and write addr 7=0x1 -> rd1 stays 0xDEADBEEF.
  - Assert rst_n=0 for 1 edge at sweep step 10 -> rd1=0, ready=0, sweep restarts from entry 0.
  - ready=1 again 32 edges after release; addr 7 then reads 0.
